// File: rtl/fft8_sol4_gen2.sv
// fft8_sol4_gen2: 8-point radix-2 DIT FFT, one butterfly stage per clock.
// Eight complex samples in, eight bins out in natural order, scaled by 1/8.
module fft8_sol4_gen2 #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] data_in_real  [7:0],
    input  logic [DW-1:0] data_in_imag  [7:0],
    output logic [DW-1:0] data_out_real [7:0],
    output logic [DW-1:0] data_out_imag [7:0],
    output logic          done
);

    localparam int PW = DW + TW;

    // Q1.15 twiddles; W^0 and W^2 never reach the multipliers
    localparam logic signed [TW-1:0] W1_RE = TW'(16'sh5A82);
    localparam logic signed [TW-1:0] W3_RE = TW'(16'shA57E);
    localparam logic signed [TW-1:0] W_IM  = TW'(16'shA57E);

    // S_OUT moves the finished work array into the output registers
    typedef enum logic [2:0] {
        S_IDLE,
        S_ST1,
        S_ST2,
        S_ST3,
        S_OUT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] work_re_q [7:0];
    logic [DW-1:0] work_re_d [7:0];
    logic [DW-1:0] work_im_q [7:0];
    logic [DW-1:0] work_im_d [7:0];
    logic [DW-1:0] out_re_q  [7:0];
    logic [DW-1:0] out_re_d  [7:0];
    logic [DW-1:0] out_im_q  [7:0];
    logic [DW-1:0] out_im_d  [7:0];
    logic [DW-1:0] bf_re     [7:0];
    logic [DW-1:0] bf_im     [7:0];
    logic          done_q, done_d;

    function automatic logic [2:0] brev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: start only honoured while idle or holding a result
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_ST1;
            S_ST1:          state_d = S_ST2;
            S_ST2:          state_d = S_ST3;
            S_ST3:          state_d = S_OUT;
            S_OUT:          state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Four parallel butterflies for the stage selected by the state
    always_comb begin : bfly
        logic [2:0]             ia, ib;
        logic [1:0]             tw;
        logic signed [DW-1:0]   ar, ai, br, bi;
        logic signed [TW-1:0]   wr, wi;
        logic signed [PW-1:0]   prr, pii, pri, pir;
        logic signed [PW:0]     sr, si;
        logic signed [DW:0]     tr, ti;
        logic signed [DW+1:0]   sum_r, sum_i, dif_r, dif_i;
        bf_re = work_re_q;
        bf_im = work_im_q;
        ia = '0;
        ib = '0;
        tw = '0;
        for (int k = 0; k < 4; k++) begin
            unique case (state_q)
                S_ST1: begin
                    ia = 3'(2 * k);
                    ib = ia + 3'd1;
                    tw = 2'd0;
                end
                S_ST2: begin
                    ia = 3'(4 * (k / 2) + k % 2);
                    ib = ia + 3'd2;
                    tw = 2'(2 * (k % 2));
                end
                default: begin
                    ia = 3'(k);
                    ib = 3'(k + 4);
                    tw = 2'(k);
                end
            endcase
            ar  = $signed(work_re_q[ia]);
            ai  = $signed(work_im_q[ia]);
            br  = $signed(work_re_q[ib]);
            bi  = $signed(work_im_q[ib]);
            wr  = (tw == 2'd1) ? W1_RE : W3_RE;
            wi  = W_IM;
            prr = PW'(wr) * PW'(br);
            pii = PW'(wi) * PW'(bi);
            pri = PW'(wr) * PW'(bi);
            pir = PW'(wi) * PW'(br);
            sr  = (PW+1)'(prr) - (PW+1)'(pii);
            si  = (PW+1)'(pri) + (PW+1)'(pir);
            unique case (tw)
                2'd0: begin
                    tr = (DW+1)'(br);
                    ti = (DW+1)'(bi);
                end
                2'd2: begin
                    tr = (DW+1)'(bi);
                    ti = -((DW+1)'(br));
                end
                default: begin
                    tr = (DW+1)'(sr >>> (TW - 1));
                    ti = (DW+1)'(si >>> (TW - 1));
                end
            endcase
            sum_r = (DW+2)'(ar) + (DW+2)'(tr);
            sum_i = (DW+2)'(ai) + (DW+2)'(ti);
            dif_r = (DW+2)'(ar) - (DW+2)'(tr);
            dif_i = (DW+2)'(ai) - (DW+2)'(ti);
            bf_re[ia] = DW'(sum_r >>> 1);
            bf_im[ia] = DW'(sum_i >>> 1);
            bf_re[ib] = DW'(dif_r >>> 1);
            bf_im[ib] = DW'(dif_i >>> 1);
        end
    end

    // Datapath: capture bit-reversed, run stages, publish result
    always_comb begin
        work_re_d = work_re_q;
        work_im_d = work_im_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        done_d    = done_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int i = 0; i < 8; i++) begin
                        work_re_d[i] = data_in_real[brev3(3'(i))];
                        work_im_d[i] = data_in_imag[brev3(3'(i))];
                    end
                    done_d = 1'b0;
                end
            end
            S_ST1, S_ST2, S_ST3: begin
                work_re_d = bf_re;
                work_im_d = bf_im;
            end
            S_OUT: begin
                out_re_d = work_re_q;
                out_im_d = work_im_q;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Work array, output registers and done flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_re_q <= '{default: '0};
            work_im_q <= '{default: '0};
            out_re_q  <= '{default: '0};
            out_im_q  <= '{default: '0};
            done_q    <= 1'b0;
        end else begin
            work_re_q <= work_re_d;
            work_im_q <= work_im_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
            done_q    <= done_d;
        end
    end

    assign data_out_real = out_re_q;
    assign data_out_imag = out_im_q;
    assign done          = done_q;

endmodule

// File: tb/tb_fft8_sol4_gen2.sv
// tb_fft8_sol4_gen2: bench for the 8-point FFT core.
// Results are compared against a floating-point DFT of the applied samples.
module tb_fft8_sol4_gen2;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din_r  [7:0];
    logic [15:0] din_i  [7:0];
    logic [15:0] dout_r [7:0];
    logic [15:0] dout_i [7:0];
    logic        done;

    int  checks = 0;
    int  failures = 0;
    real exp_r [8];
    real exp_i [8];

    fft8_sol4_gen2 #(.DW(16), .TW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_in_real  (din_r),
        .data_in_imag  (din_i),
        .data_out_real (dout_r),
        .data_out_imag (dout_i),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ideal scaled forward DFT of the current inputs, in LSB units
    function automatic void compute_model();
        for (int k = 0; k < 8; k++) begin
            real sr, si, xr, xi, th;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 8; n++) begin
                xr = real'(int'($signed(din_r[n])));
                xi = real'(int'($signed(din_i[n])));
                th = 2.0 * PI * real'(n * k) / 8.0;
                sr += xr * $cos(th) + xi * $sin(th);
                si += xi * $cos(th) - xr * $sin(th);
            end
            exp_r[k] = sr / 8.0;
            exp_i[k] = si / 8.0;
        end
    endfunction

    function automatic real max_err();
        real m, d;
        m = 0.0;
        for (int k = 0; k < 8; k++) begin
            d = real'(int'($signed(dout_r[k]))) - exp_r[k];
            if (d < 0.0) d = -d;
            if (d > m) m = d;
            d = real'(int'($signed(dout_i[k]))) - exp_i[k];
            if (d < 0.0) d = -d;
            if (d > m) m = d;
        end
        return m;
    endfunction

    function automatic bit outs_zero();
        for (int k = 0; k < 8; k++)
            if (dout_r[k] !== 16'h0 || dout_i[k] !== 16'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_random(input int amp);
        for (int n = 0; n < 8; n++) begin
            din_r[n] = 16'($urandom_range(0, 2 * amp) - amp);
            din_i[n] = 16'($urandom_range(0, 2 * amp) - amp);
        end
    endtask

    // Pulse start for one edge; lat = edges after capture until done
    task automatic start_and_wait(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        for (int n = 0; n < 8; n++) begin
            din_r[n] = 16'h0;
            din_i[n] = 16'h0;
        end
        #3;
        checks++;
        if (done !== 1'b0 || !outs_zero()) begin
            failures++;
            $display("FAIL reset_init done=%b out0=%h required done=0 outs=0",
                     done, dout_r[0]);
        end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (done !== 1'b0 || !outs_zero()) begin
            failures++;
            $display("FAIL reset_idle done=%b required 0, outs zero=%b",
                     done, outs_zero());
        end
        set_random(16383);
        start_and_wait(lat);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_run done=%b required 1", done);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || !outs_zero()) begin
            failures++;
            $display("FAIL reset_async done=%b outs zero=%b required 0/1",
                     done, outs_zero());
        end
        #1;
        rst = 1'b1;
        repeat (4) tick();
        checks++;
        if (done !== 1'b0 || !outs_zero()) begin
            failures++;
            $display("FAIL reset_release done=%b outs zero=%b required 0/1",
                     done, outs_zero());
        end
    endtask

    task automatic test_impulse();
        int lat;
        for (int n = 0; n < 8; n++) begin
            din_r[n] = 16'h0;
            din_i[n] = 16'h0;
        end
        din_r[0] = 16'h4000;
        din_i[0] = 16'h4000;
        start_and_wait(lat);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL impulse_latency got %0d required 4", lat);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dout_r[k] !== 16'h0800 || dout_i[k] !== 16'h0800) begin
                failures++;
                $display("FAIL impulse_bin%0d got (%h,%h) required (0800,0800)",
                         k, dout_r[k], dout_i[k]);
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (done !== 1'b1 || dout_r[c % 8] !== 16'h0800 ||
                dout_i[7 - c % 8] !== 16'h0800) begin
                failures++;
                $display("FAIL impulse_hold cycle %0d done=%b required 1", c, done);
            end
        end
    endtask

    task automatic test_dc();
        int lat;
        real e;
        for (int n = 0; n < 8; n++) begin
            din_r[n] = 16'h4000;
            din_i[n] = 16'h4000;
        end
        compute_model();
        start_and_wait(lat);
        e = max_err();
        checks++;
        if (lat != 4 || e > 1.0) begin
            failures++;
            $display("FAIL dc lat=%0d err=%f required lat=4 err<=1", lat, e);
        end
    endtask

    task automatic test_nyquist();
        int lat;
        real e;
        for (int n = 0; n < 8; n++) begin
            din_r[n] = (n % 2 == 0) ? 16'h4000 : 16'hC000;
            din_i[n] = 16'h0;
        end
        compute_model();
        start_and_wait(lat);
        e = max_err();
        checks++;
        if (lat != 4 || e > 1.0) begin
            failures++;
            $display("FAIL nyquist lat=%0d err=%f required lat=4 err<=1", lat, e);
        end
    endtask

    task automatic test_cosine();
        int lat;
        real e;
        for (int n = 0; n < 8; n++) begin
            din_r[n] = 16'($rtoi(16384.0 * $cos(2.0 * PI * n / 8.0) +
                           ((n == 2 || n == 6) ? 0.0 :
                            ($cos(2.0 * PI * n / 8.0) > 0.0 ? 0.5 : -0.5))));
            din_i[n] = 16'h0;
        end
        compute_model();
        start_and_wait(lat);
        e = max_err();
        checks++;
        if (lat != 4 || e > 2.0) begin
            failures++;
            $display("FAIL cosine lat=%0d err=%f required lat=4 err<=2", lat, e);
        end
        checks++;
        if (int'($signed(dout_r[1])) < 8190 || int'($signed(dout_r[7])) < 8190) begin
            failures++;
            $display("FAIL cosine_bins X1=%h X7=%h required ~2000",
                     dout_r[1], dout_r[7]);
        end
    endtask

    task automatic test_random();
        int lat;
        real e;
        for (int t = 0; t < 8; t++) begin
            set_random(16383);
            compute_model();
            start_and_wait(lat);
            e = max_err();
            checks++;
            if (lat != 4 || e > 2.0) begin
                failures++;
                $display("FAIL random%0d lat=%0d err=%f required lat=4 err<=2",
                         t, lat, e);
            end
        end
    endtask

    task automatic test_start_ignored();
        real e;
        set_random(16383);
        compute_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        set_random(16383);
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_early_done done=%b required 0", done);
        end
        tick();
        e = max_err();
        checks++;
        if (done !== 1'b1 || e > 2.0) begin
            failures++;
            $display("FAIL ignore_result done=%b err=%f required 1, err<=2", done, e);
        end
        repeat (5) tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_hold done=%b required 1", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] old_r [8];
        logic [15:0] old_i [8];
        bit   same;
        real  e;
        for (int k = 0; k < 8; k++) begin
            old_r[k] = dout_r[k];
            old_i[k] = dout_i[k];
        end
        set_random(16383);
        compute_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            same = 1'b1;
            for (int k = 0; k < 8; k++)
                if (dout_r[k] !== old_r[k] || dout_i[k] !== old_i[k]) same = 1'b0;
            checks++;
            if (done !== 1'b0 || !same) begin
                failures++;
                $display("FAIL b2b_busy cycle %0d done=%b held=%b required 0/1",
                         c, done, same);
            end
            tick();
        end
        tick();
        e = max_err();
        checks++;
        if (done !== 1'b1 || e > 2.0) begin
            failures++;
            $display("FAIL b2b_result done=%b err=%f required 1, err<=2", done, e);
        end
    endtask

    task automatic test_start_held();
        logic exp_done;
        real  e;
        set_random(16383);
        compute_model();
        start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp_done = (i % 5 == 4);
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL held_done edge %0d got %b required %b",
                         i, done, exp_done);
            end
        end
        start = 1'b0;
        e = max_err();
        checks++;
        if (e > 2.0) begin
            failures++;
            $display("FAIL held_result err=%f required <=2", e);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        set_random(16383);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || !outs_zero()) begin
            failures++;
            $display("FAIL rst_mid_now done=%b outs zero=%b required 0/1",
                     done, outs_zero());
        end
        tick();
        #2;
        rst = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done !== 1'b0 || !outs_zero()) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rst_mid_after done=%b outs zero=%b required 0/1",
                     done, outs_zero());
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_nyquist();
        test_cosine();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_start_held();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
